consistency_monitor: RTL and testbench

// Synthesisable, parametrised local-consistency monitor. Sits beside the cores, passively tapping each core's

---
 rtl/consistency_monitor.sv | 256 +++++++++++++++++++++++++
 tb/tb_consistency_monitor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/consistency_monitor.sv
// Passive load-value consistency monitor. A completed load must match the loading core's own latest write,
// or a value some other core has written, or writes within TIMEOUT cycles while the load waits in a pending table.
module consistency_monitor #(
   parameter int NCORES     = 2,
   parameter int NMEMS      = 2,
   parameter int DATA_W     = 2,
   parameter int PEND_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter int INIT_VAL   = 0,
   parameter int KIND_W     = 2,
   parameter int TX_RD      = 1,
   parameter int TX_WR      = 2,
   localparam int AW        = (NMEMS > 1) ? $clog2(NMEMS) : 1,
   localparam int PCW       = $clog2(PEND_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NCORES-1:0]          wr_src_rdy,
   input  logic [NCORES-1:0]          wr_tgt_rdy,
   input  logic [NCORES*KIND_W-1:0]   wr_kind,
   input  logic [NCORES*AW-1:0]       wr_addr,
   input  logic [NCORES*DATA_W-1:0]   wr_data,
   input  logic [NCORES-1:0]          rd_src_rdy,
   input  logic [NCORES-1:0]          rd_tgt_rdy,
   input  logic [NCORES*KIND_W-1:0]   rd_kind,
   input  logic [NCORES*AW-1:0]       rd_addr,
   input  logic [NCORES*DATA_W-1:0]   rd_data,
   input  logic                       clr_err,
   output logic                       err_timeout,
   output logic                       err_overflow,
   output logic [NCORES-1:0]          err_core,
   output logic [AW-1:0]              err_addr,
   output logic [DATA_W-1:0]          err_val,
   output logic [PCW-1:0]             pend_cnt
);

   localparam int CIW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int NV  = 1 << DATA_W;

   logic              w_wr_ev [NCORES];
   logic [AW-1:0]     w_wr_a  [NCORES];
   logic [DATA_W-1:0] w_wr_d  [NCORES];
   logic              w_rd_ev [NCORES];
   logic [AW-1:0]     w_rd_a  [NCORES];
   logic [DATA_W-1:0] w_rd_d  [NCORES];

   logic [DATA_W-1:0] r_last_val [NCORES][NMEMS];
   logic              r_last_vld [NCORES][NMEMS];
   logic [NV-1:0]     r_wrote    [NCORES][NMEMS];

   logic [PEND_DEPTH-1:0] r_pv;
   logic [CIW-1:0]        r_pc [PEND_DEPTH];
   logic [AW-1:0]         r_pa [PEND_DEPTH];
   logic [DATA_W-1:0]     r_pd [PEND_DEPTH];
   logic [TW-1:0]         r_pt [PEND_DEPTH];

   logic [PEND_DEPTH-1:0] w_res;
   logic [PEND_DEPTH-1:0] w_exp;
   logic [PEND_DEPTH-1:0] w_alloc;
   logic [CIW-1:0]        w_ac [PEND_DEPTH];
   logic [AW-1:0]         w_aa [PEND_DEPTH];
   logic [DATA_W-1:0]     w_ad [PEND_DEPTH];

   logic [NCORES-1:0]     w_pass;
   logic [NCORES-1:0]     w_ovf;
   logic [NCORES-1:0]     w_fail_core;
   logic                  w_fail;
   logic [AW-1:0]         w_fa;
   logic [DATA_W-1:0]     w_fv;
   logic [PCW-1:0]        w_cnt_nxt;
   logic                  r_armed;

   always_comb begin
      for (int c = 0; c < NCORES; c++) begin
         w_wr_ev[c] = wr_src_rdy[c] && wr_tgt_rdy[c] &&
                      (wr_kind[c*KIND_W +: KIND_W] == KIND_W'(TX_WR));
         w_wr_a[c]  = wr_addr[c*AW +: AW];
         w_wr_d[c]  = wr_data[c*DATA_W +: DATA_W];
         w_rd_ev[c] = rd_src_rdy[c] && rd_tgt_rdy[c] &&
                      (rd_kind[c*KIND_W +: KIND_W] == KIND_W'(TX_RD));
         w_rd_a[c]  = rd_addr[c*AW +: AW];
         w_rd_d[c]  = rd_data[c*DATA_W +: DATA_W];
      end
   end

   // Immediate justification uses pre-update history; a same-cycle own write never counts.
   always_comb begin
      for (int c = 0; c < NCORES; c++) begin
         w_pass[c] = (w_rd_d[c] == DATA_W'(INIT_VAL)) ||
                     (r_last_vld[c][w_rd_a[c]] && (r_last_val[c][w_rd_a[c]] == w_rd_d[c]));
         for (int o = 0; o < NCORES; o++) begin
            if (o != c && (r_wrote[o][w_rd_a[c]][w_rd_d[c]] ||
                (w_wr_ev[o] && w_wr_a[o] == w_rd_a[c] && w_wr_d[o] == w_rd_d[c])))
               w_pass[c] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int s = 0; s < PEND_DEPTH; s++) begin
         w_res[s] = 1'b0;
         for (int c = 0; c < NCORES; c++) begin
            if (r_pv[s] && w_wr_ev[c] && (r_pc[s] != CIW'(c)) &&
                w_wr_a[c] == r_pa[s] && w_wr_d[c] == r_pd[s])
               w_res[s] = 1'b1;
         end
         w_exp[s] = r_pv[s] && !w_res[s] && (r_pt[s] == TW'(1));
      end
   end

   // Slot search runs against the registered valid mask, so slots freed this cycle stay unavailable.
   always_comb begin : alloc_blk
      logic [PEND_DEPTH-1:0] taken;
      logic                  found;
      taken   = r_pv;
      found   = 1'b0;
      w_alloc = '0;
      w_ovf   = '0;
      for (int s = 0; s < PEND_DEPTH; s++) begin
         w_ac[s] = '0;
         w_aa[s] = '0;
         w_ad[s] = '0;
      end
      for (int c = 0; c < NCORES; c++) begin
         found = 1'b0;
         if (w_rd_ev[c] && !w_pass[c]) begin
            for (int s = 0; s < PEND_DEPTH; s++) begin
               if (!found && !taken[s]) begin
                  taken[s]   = 1'b1;
                  w_alloc[s] = 1'b1;
                  w_ac[s]    = CIW'(c);
                  w_aa[s]    = w_rd_a[c];
                  w_ad[s]    = w_rd_d[c];
                  found      = 1'b1;
               end
            end
            w_ovf[c] = !found;
         end
      end
   end

   always_comb begin
      w_fail      = 1'b0;
      w_fa        = '0;
      w_fv        = '0;
      w_fail_core = w_ovf;
      for (int c = 0; c < NCORES; c++) begin
         if (w_ovf[c] && !w_fail) begin
            w_fail = 1'b1;
            w_fa   = w_rd_a[c];
            w_fv   = w_rd_d[c];
         end
      end
      for (int c = 0; c < NCORES; c++) begin
         for (int s = 0; s < PEND_DEPTH; s++) begin
            if (w_exp[s] && r_pc[s] == CIW'(c) && !w_fail) begin
               w_fail = 1'b1;
               w_fa   = r_pa[s];
               w_fv   = r_pd[s];
            end
         end
      end
      for (int s = 0; s < PEND_DEPTH; s++) begin
         if (w_exp[s])
            w_fail_core[r_pc[s]] = 1'b1;
      end
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int s = 0; s < PEND_DEPTH; s++) begin
         if (w_alloc[s] || (r_pv[s] && !w_res[s] && !w_exp[s]))
            w_cnt_nxt = w_cnt_nxt + PCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCORES; c++) begin
            for (int m = 0; m < NMEMS; m++) begin
               r_last_val[c][m] <= '0;
               r_last_vld[c][m] <= 1'b0;
               r_wrote[c][m]    <= '0;
            end
         end
      end else begin
         for (int c = 0; c < NCORES; c++) begin
            if (w_wr_ev[c]) begin
               r_last_val[c][w_wr_a[c]]            <= w_wr_d[c];
               r_last_vld[c][w_wr_a[c]]            <= 1'b1;
               r_wrote[c][w_wr_a[c]][w_wr_d[c]]    <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pv <= '0;
         for (int s = 0; s < PEND_DEPTH; s++) begin
            r_pc[s] <= '0;
            r_pa[s] <= '0;
            r_pd[s] <= '0;
            r_pt[s] <= '0;
         end
      end else begin
         for (int s = 0; s < PEND_DEPTH; s++) begin
            if (w_alloc[s]) begin
               r_pv[s] <= 1'b1;
               r_pc[s] <= w_ac[s];
               r_pa[s] <= w_aa[s];
               r_pd[s] <= w_ad[s];
               r_pt[s] <= TW'(TIMEOUT);
            end else if (w_res[s] || w_exp[s]) begin
               r_pv[s] <= 1'b0;
            end else if (r_pv[s]) begin
               r_pt[s] <= r_pt[s] - TW'(1);
            end
         end
      end
   end

   // A failure in the clearing cycle survives the clear and takes the fresh record.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
         err_core     <= '0;
         err_addr     <= '0;
         err_val      <= '0;
         r_armed      <= 1'b1;
         pend_cnt     <= '0;
      end else begin
         pend_cnt <= w_cnt_nxt;
         if (clr_err) begin
            err_timeout  <= |w_exp;
            err_overflow <= |w_ovf;
            err_core     <= w_fail_core;
            err_addr     <= w_fa;
            err_val      <= w_fv;
            r_armed      <= !w_fail;
         end else begin
            err_timeout  <= err_timeout | (|w_exp);
            err_overflow <= err_overflow | (|w_ovf);
            err_core     <= err_core | w_fail_core;
            if (w_fail && r_armed) begin
               err_addr <= w_fa;
               err_val  <= w_fv;
               r_armed  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_consistency_monitor.sv
// Bench for consistency_monitor: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model built on write-history sets and absolute deadlines.
module tb_consistency_monitor;

   localparam int NC = 2, NM = 2, DW = 2, PD = 4, TO = 64, IV = 0;
   localparam int KW = 2, K_RD = 1, K_WR = 2, AW = 1, NV = 4, CW = 3;

   logic clk = 1'b0;
   logic rst;
   logic [NC-1:0]    wr_src_rdy, wr_tgt_rdy, rd_src_rdy, rd_tgt_rdy;
   logic [NC*KW-1:0] wr_kind, rd_kind;
   logic [NC*AW-1:0] wr_addr, rd_addr;
   logic [NC*DW-1:0] wr_data, rd_data;
   logic             clr_err;
   logic             err_timeout, err_overflow;
   logic [NC-1:0]    err_core;
   logic [AW-1:0]    err_addr;
   logic [DW-1:0]    err_val;
   logic [CW-1:0]    pend_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   consistency_monitor #(
      .NCORES(NC), .NMEMS(NM), .DATA_W(DW), .PEND_DEPTH(PD), .TIMEOUT(TO), .INIT_VAL(IV),
      .KIND_W(KW), .TX_RD(K_RD), .TX_WR(K_WR)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_src_rdy(wr_src_rdy), .wr_tgt_rdy(wr_tgt_rdy), .wr_kind(wr_kind),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_src_rdy(rd_src_rdy), .rd_tgt_rdy(rd_tgt_rdy), .rd_kind(rd_kind),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .clr_err(clr_err),
      .err_timeout(err_timeout), .err_overflow(err_overflow), .err_core(err_core),
      .err_addr(err_addr), .err_val(err_val), .pend_cnt(pend_cnt)
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      bit     v;
      int     core;
      int     addr;
      int     val;
      longint dl;
   } pent_t;

   bit         m_seen   [NC][NM][NV];
   int         m_latest [NC][NM];
   pent_t      m_pt     [PD];
   longint     m_cyc = 0;
   bit         m_to, m_ovf, m_armed;
   bit [NC-1:0] m_core;
   int         m_ea, m_ev, m_cnt;

   task automatic model_reset();
      for (int c = 0; c < NC; c++)
         for (int a = 0; a < NM; a++) begin
            m_latest[c][a] = -1;
            for (int v = 0; v < NV; v++) m_seen[c][a][v] = 1'b0;
         end
      for (int s = 0; s < PD; s++) m_pt[s].v = 1'b0;
      m_to = 0; m_ovf = 0; m_core = '0; m_ea = 0; m_ev = 0; m_armed = 1; m_cnt = 0;
   endtask

   task automatic model_step();
      bit wev[NC]; bit lev[NC]; int wa[NC]; int wd[NC]; int la[NC]; int ld[NC];
      bit fr[PD]; bit ex[PD]; bit tk[PD]; bit ovf[NC];
      bit [NC-1:0] fmask;
      bit anyf, ok, any_ex, any_ovf;
      int fa, fv, slot;
      fmask = '0; anyf = 0; fa = 0; fv = 0; any_ex = 0; any_ovf = 0;
      for (int c = 0; c < NC; c++) begin
         wev[c] = wr_src_rdy[c] && wr_tgt_rdy[c] && int'(wr_kind[c*KW +: KW]) == K_WR;
         wa[c]  = int'(wr_addr[c*AW +: AW]);
         wd[c]  = int'(wr_data[c*DW +: DW]);
         lev[c] = rd_src_rdy[c] && rd_tgt_rdy[c] && int'(rd_kind[c*KW +: KW]) == K_RD;
         la[c]  = int'(rd_addr[c*AW +: AW]);
         ld[c]  = int'(rd_data[c*DW +: DW]);
      end
      for (int s = 0; s < PD; s++) begin
         fr[s] = 0; ex[s] = 0; tk[s] = m_pt[s].v;
         if (m_pt[s].v) begin
            for (int c = 0; c < NC; c++)
               if (wev[c] && c != m_pt[s].core && wa[c] == m_pt[s].addr && wd[c] == m_pt[s].val)
                  fr[s] = 1;
            if (!fr[s] && m_cyc == m_pt[s].dl) ex[s] = 1;
         end
      end
      for (int c = 0; c < NC; c++) begin
         ovf[c] = 0;
         if (lev[c]) begin
            ok = (ld[c] == IV) || (m_latest[c][la[c]] == ld[c]);
            for (int o = 0; o < NC; o++)
               if (o != c && (m_seen[o][la[c]][ld[c]] || (wev[o] && wa[o] == la[c] && wd[o] == ld[c])))
                  ok = 1;
            if (!ok) begin
               slot = -1;
               for (int s = 0; s < PD; s++) if (slot < 0 && !tk[s]) slot = s;
               if (slot < 0) ovf[c] = 1;
               else begin
                  tk[slot] = 1;
                  m_pt[slot].v = 1; m_pt[slot].core = c; m_pt[slot].addr = la[c];
                  m_pt[slot].val = ld[c]; m_pt[slot].dl = m_cyc + TO;
               end
            end
         end
      end
      for (int c = 0; c < NC; c++)
         if (ovf[c]) begin
            fmask[c] = 1; any_ovf = 1;
            if (!anyf) begin anyf = 1; fa = la[c]; fv = ld[c]; end
         end
      for (int c = 0; c < NC; c++)
         for (int s = 0; s < PD; s++)
            if (ex[s] && m_pt[s].core == c) begin
               fmask[c] = 1; any_ex = 1;
               if (!anyf) begin anyf = 1; fa = m_pt[s].addr; fv = m_pt[s].val; end
            end
      if (clr_err) begin
         m_to = any_ex; m_ovf = any_ovf; m_core = fmask;
         m_ea = fa; m_ev = fv; m_armed = !anyf;
      end else begin
         m_to = m_to | any_ex; m_ovf = m_ovf | any_ovf; m_core = m_core | fmask;
         if (anyf && m_armed) begin m_ea = fa; m_ev = fv; m_armed = 0; end
      end
      for (int c = 0; c < NC; c++)
         if (wev[c]) begin
            m_latest[c][wa[c]] = wd[c];
            m_seen[c][wa[c]][wd[c]] = 1;
         end
      for (int s = 0; s < PD; s++)
         if (fr[s] || ex[s]) m_pt[s].v = 0;
      m_cnt = 0;
      for (int s = 0; s < PD; s++) if (m_pt[s].v) m_cnt++;
      m_cyc++;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      logic [NC+AW+DW+CW+1:0] got, exp;
      got = {err_timeout, err_overflow, err_core, err_addr, err_val, pend_cnt};
      exp = {m_to, m_ovf, m_core, AW'(m_ea), DW'(m_ev), CW'(m_cnt)};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t got to=%0b ovf=%0b core=%b addr=%0d val=%0d cnt=%0d want to=%0b ovf=%0b core=%b addr=%0d val=%0d cnt=%0d",
                  $time, err_timeout, err_overflow, err_core, err_addr, err_val, pend_cnt,
                  m_to, m_ovf, m_core, m_ea, m_ev, m_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(string nm, int act, int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d at t=%0t", nm, act, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_src_rdy = '0; wr_tgt_rdy = '0; wr_kind = '0; wr_addr = '0; wr_data = '0;
      rd_src_rdy = '0; rd_tgt_rdy = '0; rd_kind = '0; rd_addr = '0; rd_data = '0;
      clr_err = 1'b0;
   endtask

   task automatic drv_wr(int c, int a, int d);
      wr_src_rdy[c] = 1'b1; wr_tgt_rdy[c] = 1'b1;
      wr_kind[c*KW +: KW] = KW'(K_WR);
      wr_addr[c*AW +: AW] = AW'(a);
      wr_data[c*DW +: DW] = DW'(d);
   endtask

   task automatic drv_rd(int c, int a, int d);
      rd_src_rdy[c] = 1'b1; rd_tgt_rdy[c] = 1'b1;
      rd_kind[c*KW +: KW] = KW'(K_RD);
      rd_addr[c*AW +: AW] = AW'(a);
      rd_data[c*DW +: DW] = DW'(d);
   endtask

   task automatic chk_clean(string nm);
      chk({nm, "_to"},   int'(err_timeout), 0);
      chk({nm, "_ovf"},  int'(err_overflow), 0);
      chk({nm, "_core"}, int'(err_core), 0);
      chk({nm, "_addr"}, int'(err_addr), 0);
      chk({nm, "_val"},  int'(err_val), 0);
   endtask

   int wr_pct, rd_pct;

   initial begin
      idle();
      rst = 1'b0;
      repeat (3) tick();
      chk_clean("reset");
      chk("reset_pend", int'(pend_cnt), 0);
      rst = 1'b1;
      tick();

      // own latest write justifies the load
      drv_wr(0, 0, 2); tick(); idle();
      drv_rd(0, 0, 2); tick(); idle();
      tick();
      chk("own_pass_pend", int'(pend_cnt), 0);
      chk_clean("own_pass");

      // load resolved by a later write from the other core
      drv_rd(1, 1, 3); tick(); idle();
      chk("late_wr_pend1", int'(pend_cnt), 1);
      repeat (4) tick();
      drv_wr(0, 1, 3); tick(); idle();
      chk("late_wr_pend0", int'(pend_cnt), 0);
      chk_clean("late_wr");

      // unjustified load times out exactly TO edges after it is taken
      drv_rd(1, 0, 1); tick(); idle();
      repeat (TO - 1) tick();
      chk("to_early", int'(err_timeout), 0);
      tick();
      chk("to_flag", int'(err_timeout), 1);
      chk("to_core", int'(err_core), 2);
      chk("to_addr", int'(err_addr), 0);
      chk("to_val",  int'(err_val), 1);
      chk("to_pend", int'(pend_cnt), 0);
      clr_err = 1'b1; tick(); idle();
      chk_clean("to_clr");

      // stale own value is not accepted
      drv_wr(0, 0, 1); tick();
      idle(); drv_wr(0, 0, 2); tick(); idle();
      drv_rd(0, 0, 1); tick(); idle();
      chk("stale_pend", int'(pend_cnt), 1);
      repeat (TO - 1) tick();
      chk("stale_early", int'(err_timeout), 0);
      tick();
      chk("stale_to", int'(err_timeout), 1);
      chk("stale_core", int'(err_core), 1);
      clr_err = 1'b1; tick(); idle();

      // PD+1 unjustified loads: last one overflows
      for (int i = 0; i < PD; i++) begin drv_rd(1, 1, 1); tick(); end
      chk("ovf_pre", int'(err_overflow), 0);
      chk("ovf_full", int'(pend_cnt), PD);
      drv_rd(1, 1, 1); tick(); idle();
      chk("ovf_flag", int'(err_overflow), 1);
      chk("ovf_core", int'(err_core), 2);
      chk("ovf_addr", int'(err_addr), 1);
      chk("ovf_val",  int'(err_val), 1);
      chk("ovf_pend", int'(pend_cnt), PD);
      rst = 1'b0; tick(); rst = 1'b1;

      // async reset with entries pending
      for (int i = 0; i < 3; i++) begin drv_rd(1, 1, 1); tick(); end
      idle();
      chk("rst3_pend", int'(pend_cnt), 3);
      rst = 1'b0; #1;
      chk("rst_async_pend", int'(pend_cnt), 0);
      chk_clean("rst_async");
      tick(); rst = 1'b1;
      repeat (TO + 5) tick();
      chk("rst_no_to", int'(err_timeout), 0);
      chk("rst_no_pend", int'(pend_cnt), 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         case ((i / 400) % 4)
            0: begin wr_pct = 30; rd_pct = 30; end
            1: begin wr_pct = 5;  rd_pct = 60; end
            2: begin wr_pct = 60; rd_pct = 10; end
            default: begin wr_pct = 15; rd_pct = 15; end
         endcase
         for (int c = 0; c < NC; c++) begin
            wr_src_rdy[c] = ($urandom_range(0, 99) < wr_pct);
            wr_tgt_rdy[c] = ($urandom_range(0, 3) != 0);
            wr_kind[c*KW +: KW] = ($urandom_range(0, 7) == 0) ? KW'(K_RD) : KW'(K_WR);
            wr_addr[c*AW +: AW] = AW'($urandom_range(0, NM - 1));
            wr_data[c*DW +: DW] = DW'($urandom_range(0, NV - 1));
            rd_src_rdy[c] = ($urandom_range(0, 99) < rd_pct);
            rd_tgt_rdy[c] = ($urandom_range(0, 3) != 0);
            rd_kind[c*KW +: KW] = ($urandom_range(0, 7) == 0) ? KW'(K_WR) : KW'(K_RD);
            rd_addr[c*AW +: AW] = AW'($urandom_range(0, NM - 1));
            rd_data[c*DW +: DW] = DW'($urandom_range(0, NV - 1));
         end
         clr_err = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 799) == 0) begin
            rst = 1'b0;
            tick(); tick();
            rst = 1'b1;
         end
         tick();
      end
      idle();
      repeat (TO + 2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
